hist_bin_reader: RTL

Readout engine for the 1024×24-bit histogram dual-port RAM. On a start pulse it sweeps every bin address in order, absorbs the RAM's one-cycle read latency, and streams bin counts out on a valid/ready interface. It optionally writes zero back to each bin after the bin is read (clear-on-read), and it reports the frame's total count. The block sits between the histogram RAM read/write ports and the frame packetizer / USB uplink.

---
 rtl/hist_bin_reader_pkg.sv | 18 +
 rtl/hist_skid_buf.sv | 51 +++++
 rtl/hist_bin_reader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hist_bin_reader_pkg.sv
// Shared constants and FSM state type for the histogram bin readout engine.
package hist_bin_reader_pkg;

    localparam int unsigned DATA_W   = 24;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned NUM_BINS = 1 << ADDR_W;
    localparam int unsigned SUM_W    = DATA_W + ADDR_W;

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/hist_skid_buf.sv
// Two-entry FIFO of {last, data} that decouples RAM read latency from output backpressure.
module hist_skid_buf
    import hist_bin_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] data_q [2];
    logic [1:0]       last_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= push_data;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_data  = data_q[rd_ptr_q];
    assign out_last  = last_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0);
    assign occupancy = count_q;

endmodule

// File: rtl/hist_bin_reader.sv
// Sweeps all histogram bins, streams counts on valid/ready, optionally clears each bin
// after it is read and accumulates the frame total.
module hist_bin_reader
    import hist_bin_reader_pkg::*;
(
    input  logic              RdClock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              ClearOnRead,
    output logic              Busy,
    output logic              Done,
    output logic [SUM_W-1:0]  FrameSum,
    output logic [ADDR_W-1:0] RdAddress,
    output logic              RdClockEn,
    input  logic [DATA_W-1:0] Q,
    output logic [ADDR_W-1:0] WrAddress,
    output logic              WE,
    output logic              WrClockEn,
    output logic [DATA_W-1:0] Data,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
    logic              clr_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] tag_q;
    logic [SUM_W-1:0]  sum_q;
    logic              we_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic [1:0] occ;
    logic [2:0] credit_use;
    logic       push;
    logic       pop;
    logic       rd_en;
    logic       start_ok;

    assign push = inflight_q;
    assign pop  = OutValid & OutReady;

    // Buffer fill after this cycle's push/pop; a new read is only safe if it leaves a free slot.
    assign credit_use = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    // Counter MSB set means every bin has been issued.
    assign rd_en = (state_q == StRead) && !rd_addr_q[ADDR_W] && (credit_use < 3'd2);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        start_ok  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d   = StRead;
                    rd_addr_d = '0;
                    start_ok  = 1'b1;
                end
            end
            StRead: begin
                if (rd_en) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q[ADDR_W-1:0] == LAST_BIN) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Leave once the final beat is popping and nothing is left behind it.
                if (credit_use == 3'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge RdClock) begin
        if (Reset) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            clr_q      <= 1'b0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            sum_q      <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= rd_en;
            if (rd_en) begin
                tag_q <= rd_addr_q[ADDR_W-1:0];
            end
            if (start_ok) begin
                clr_q <= ClearOnRead;
                sum_q <= '0;
            end else if (push) begin
                sum_q <= sum_q + SUM_W'(Q);
            end
            we_q <= push & clr_q;
            if (push) begin
                wr_addr_q <= tag_q;
            end
        end
    end

    hist_skid_buf #(
        .WIDTH(DATA_W)
    ) u_skid (
        .clk      (RdClock),
        .rst      (Reset),
        .push     (push),
        .push_data(Q),
        .push_last(tag_q == LAST_BIN),
        .pop      (pop),
        .out_data (OutData),
        .out_last (OutLast),
        .out_valid(OutValid),
        .occupancy(occ)
    );

    assign Busy      = (state_q != StIdle);
    assign Done      = (state_q == StDone);
    assign FrameSum  = sum_q;
    assign RdAddress = rd_addr_q[ADDR_W-1:0];
    assign RdClockEn = rd_en;
    assign WrAddress = wr_addr_q;
    assign WE        = we_q;
    assign WrClockEn = we_q;
    assign Data      = '0;

endmodule
